// File: rtl/ntp_client_axi_regs.sv
// AXI4-Lite register block for the NTP client core: control outputs, status inputs,
// coherent 64-bit offset readback and a sticky sync-done interrupt.
module ntp_client_axi_regs #(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 5,
    parameter logic [31:0] C_POLL_DEFAULT     = 32'd16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                      s_axi_awprot,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                      s_axi_arprot,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic                            ntp_enable,
    output logic                            ntp_start,
    output logic [31:0]                     server_addr,
    output logic [31:0]                     poll_interval,
    input  logic                            core_busy,
    input  logic                            sync_valid,
    input  logic [63:0]                     offset,
    input  logic                            sync_done,
    output logic                            irq
);

    logic        awready_r, wready_r, bvalid_r, arready_r, rvalid_r;
    logic [31:0] rdata_r, ctrl_r, server_addr_r, poll_interval_r, scratch_r, shadow_r;
    logic        irq_status_r, ntp_start_r, irq_r;
    logic        wr_accept_s, wr_en_s, rd_accept_s, rd_en_s, irq_clr_s;
    logic [2:0]  wr_idx_s, rd_idx_s;
    logic [31:0] rd_data_s;
    logic        unused_s;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        end
        return res;
    endfunction

    assign wr_idx_s    = s_axi_awaddr[4:2];
    assign rd_idx_s    = s_axi_araddr[4:2];
    // A write needs both AW and W present; the update lands in the ready cycle.
    assign wr_accept_s = s_axi_awvalid & s_axi_wvalid & ~awready_r & ~bvalid_r;
    assign wr_en_s     = awready_r & wready_r & s_axi_awvalid & s_axi_wvalid;
    assign rd_accept_s = s_axi_arvalid & ~arready_r & ~rvalid_r;
    assign rd_en_s     = arready_r & s_axi_arvalid;
    assign irq_clr_s   = wr_en_s & (wr_idx_s == 3'd7) & s_axi_wstrb[0] & s_axi_wdata[0];
    assign unused_s    = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // Read data decode
    always_comb begin
        rd_data_s = 32'd0;
        case (rd_idx_s)
            3'd0:    rd_data_s = ctrl_r;
            3'd1:    rd_data_s = server_addr_r;
            3'd2:    rd_data_s = poll_interval_r;
            3'd3:    rd_data_s = scratch_r;
            3'd4:    rd_data_s = {30'd0, sync_valid, core_busy};
            3'd5:    rd_data_s = offset[63:32];
            3'd6:    rd_data_s = shadow_r;
            3'd7:    rd_data_s = {31'd0, irq_status_r};
            default: rd_data_s = 32'd0;
        endcase
    end

    // AXI handshake and response channel state
    always_ff @(posedge clock) begin
        if (reset) begin
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= 32'd0;
        end else begin
            awready_r <= wr_accept_s;
            wready_r  <= wr_accept_s;
            arready_r <= rd_accept_s;
            if (wr_en_s) begin
                bvalid_r <= 1'b1;
            end else if (s_axi_bready) begin
                bvalid_r <= 1'b0;
            end
            if (rd_en_s) begin
                rvalid_r <= 1'b1;
                rdata_r  <= rd_data_s;
            end else if (s_axi_rready) begin
                rvalid_r <= 1'b0;
            end
        end
    end

    // Software-writable registers; CTRL bit1 is a strobe and never stored
    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_r          <= 32'd0;
            server_addr_r   <= 32'd0;
            poll_interval_r <= C_POLL_DEFAULT;
            scratch_r       <= 32'd0;
            ntp_start_r     <= 1'b0;
        end else begin
            ntp_start_r <= wr_en_s & (wr_idx_s == 3'd0) & s_axi_wstrb[0] & s_axi_wdata[1];
            if (wr_en_s) begin
                case (wr_idx_s)
                    3'd0:    ctrl_r          <= apply_wstrb(ctrl_r, s_axi_wdata, s_axi_wstrb) & 32'hFFFF_FFFD;
                    3'd1:    server_addr_r   <= apply_wstrb(server_addr_r, s_axi_wdata, s_axi_wstrb);
                    3'd2:    poll_interval_r <= apply_wstrb(poll_interval_r, s_axi_wdata, s_axi_wstrb);
                    3'd3:    scratch_r       <= apply_wstrb(scratch_r, s_axi_wdata, s_axi_wstrb);
                    default: ;
                endcase
            end
        end
    end

    // Offset low-word shadow (captured with the HI read) and the sticky interrupt
    always_ff @(posedge clock) begin
        if (reset) begin
            shadow_r     <= 32'd0;
            irq_status_r <= 1'b0;
            irq_r        <= 1'b0;
        end else begin
            if (rd_en_s && (rd_idx_s == 3'd5)) begin
                shadow_r <= offset[31:0];
            end
            if (sync_done) begin
                irq_status_r <= 1'b1;
            end else if (irq_clr_s) begin
                irq_status_r <= 1'b0;
            end
            irq_r <= irq_status_r & ctrl_r[2];
        end
    end

    assign s_axi_awready = awready_r;
    assign s_axi_wready  = wready_r;
    assign s_axi_bvalid  = bvalid_r;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_arready = arready_r;
    assign s_axi_rvalid  = rvalid_r;
    assign s_axi_rdata   = rdata_r;
    assign s_axi_rresp   = 2'b00;
    assign ntp_enable    = ctrl_r[0];
    assign ntp_start     = ntp_start_r;
    assign server_addr   = server_addr_r;
    assign poll_interval = poll_interval_r;
    assign irq           = irq_r;

endmodule

// File: tb/tb_ntp_client_axi_regs.sv
// Directed bench for ntp_client_axi_regs; read results are checked against a
// queue of expected values pushed when each read is issued.
module tb_ntp_client_axi_regs;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  s_axi_awaddr, s_axi_araddr;
    logic [2:0]  s_axi_awprot, s_axi_arprot;
    logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
    logic [31:0] s_axi_wdata, s_axi_rdata;
    logic [3:0]  s_axi_wstrb;
    logic [1:0]  s_axi_bresp, s_axi_rresp;
    logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
    logic        s_axi_rvalid, s_axi_rready;
    logic        ntp_enable, ntp_start, core_busy, sync_valid, sync_done, irq;
    logic [31:0] server_addr, poll_interval;
    logic [63:0] offset;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          start_cnt = 0;
    int          start_base;
    logic [31:0] exp_q[$];
    logic        aw_early, ar_seen, rd_done;

    ntp_client_axi_regs dut (
        .clock(clock), .reset(reset),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .ntp_enable(ntp_enable), .ntp_start(ntp_start),
        .server_addr(server_addr), .poll_interval(poll_interval),
        .core_busy(core_busy), .sync_valid(sync_valid), .offset(offset),
        .sync_done(sync_done), .irq(irq)
    );

    always #5 clock = ~clock;

    // Counts cycles in which the start strobe is high
    always @(posedge clock) begin
        if (ntp_start) start_cnt <= start_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic timeout(input string tag);
        total_cnt++;
        $error("FAIL %s: observed timeout expected handshake", tag);
    endtask

    task automatic wait_awready(input string tag);
        int n = 0;
        do begin
            @(posedge clock); #1; n++;
        end while (!s_axi_awready && n < 20);
        if (!s_axi_awready) timeout(tag);
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input bit sync_at_hs);
        s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        wait_awready("wr_awready");
        check("wr_wready", s_axi_wready, 1'b1);
        if (sync_at_hs) sync_done = 1'b1;
        @(posedge clock); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; sync_done = 1'b0;
        check("wr_bvalid", s_axi_bvalid, 1'b1);
        check("wr_bresp", s_axi_bresp, 2'b00);
        @(posedge clock); #1;
    endtask

    task automatic axi_read(input logic [4:0] addr, input logic [31:0] exp);
        int n = 0;
        exp_q.push_back(exp);
        s_axi_araddr = addr; s_axi_arvalid = 1'b1;
        do begin
            @(posedge clock); #1; n++;
        end while (!s_axi_arready && n < 20);
        if (!s_axi_arready) timeout("rd_arready");
        @(posedge clock); #1;
        s_axi_arvalid = 1'b0;
        check("rd_rvalid", s_axi_rvalid, 1'b1);
        check("rd_rresp", s_axi_rresp, 2'b00);
        if (exp_q.size() > 0) check($sformatf("rd_data@%0h", addr), s_axi_rdata, exp_q.pop_front());
        @(posedge clock); #1;
    endtask

    initial begin
        reset = 1'b1;
        s_axi_awaddr = 5'd0; s_axi_araddr = 5'd0; s_axi_awprot = 3'd0; s_axi_arprot = 3'd0;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_wdata = 32'd0; s_axi_wstrb = 4'd0;
        s_axi_bready = 1'b1; s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
        core_busy = 1'b0; sync_valid = 1'b0; sync_done = 1'b0; offset = 64'd0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_awready", s_axi_awready, 1'b0);
        check("rst_wready", s_axi_wready, 1'b0);
        check("rst_bvalid", s_axi_bvalid, 1'b0);
        check("rst_arready", s_axi_arready, 1'b0);
        check("rst_rvalid", s_axi_rvalid, 1'b0);
        check("rst_rdata", s_axi_rdata, 32'd0);
        check("rst_start", ntp_start, 1'b0);
        check("rst_irq", irq, 1'b0);
        check("rst_enable", ntp_enable, 1'b0);
        check("rst_server", server_addr, 32'd0);
        check("rst_poll", poll_interval, 32'd16);
        reset = 1'b0;
        @(posedge clock); #1;
        axi_read(5'h08, 32'd16);

        // Basic RW registers
        axi_write(5'h00, 32'd1, 4'hF, 1'b0);
        axi_write(5'h04, 32'd2, 4'hF, 1'b0);
        axi_write(5'h08, 32'd3, 4'hF, 1'b0);
        axi_write(5'h0C, 32'd4, 4'hF, 1'b0);
        axi_read(5'h00, 32'd1);
        axi_read(5'h04, 32'd2);
        axi_read(5'h08, 32'd3);
        axi_read(5'h0C, 32'd4);
        check("enable_out", ntp_enable, 1'b1);
        check("server_out", server_addr, 32'd2);
        check("poll_out", poll_interval, 32'd3);

        // Byte strobes, RO STATUS
        axi_write(5'h04, 32'h12345678, 4'hF, 1'b0);
        axi_write(5'h04, 32'hFFFFFFFF, 4'b0101, 1'b0);
        axi_read(5'h04, 32'h12FF56FF);
        axi_write(5'h10, 32'hFFFFFFFF, 4'hF, 1'b0);
        core_busy = 1'b1; sync_valid = 1'b0;
        axi_read(5'h10, 32'd1);
        core_busy = 1'b0; sync_valid = 1'b1;
        axi_read(5'h10, 32'd2);

        // Start strobe
        start_base = start_cnt;
        axi_write(5'h00, 32'd2, 4'hF, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        check("start_pulse_cycles", start_cnt - start_base, 1);
        axi_read(5'h00, 32'd0);

        // Coherent offset pair; low address bits ignored
        offset = 64'h00000001_80000000;
        axi_read(5'h14, 32'h00000001);
        offset = 64'h00000002_00000000;
        axi_read(5'h18, 32'h80000000);
        axi_read(5'h1B, 32'h80000000);

        // Interrupt: set, set-beats-clear, clear
        axi_write(5'h00, 32'd4, 4'hF, 1'b0);
        check("irq_idle", irq, 1'b0);
        sync_done = 1'b1;
        @(posedge clock); #1;
        sync_done = 1'b0;
        @(posedge clock); #1;
        check("irq_set", irq, 1'b1);
        axi_read(5'h1C, 32'd1);
        axi_write(5'h1C, 32'd1, 4'hF, 1'b1);
        axi_read(5'h1C, 32'd1);
        check("irq_set_wins", irq, 1'b1);
        axi_write(5'h1C, 32'd1, 4'hF, 1'b0);
        check("irq_cleared", irq, 1'b0);
        axi_read(5'h1C, 32'd0);

        // AW waits for W; bvalid held; second write stalls; concurrent read
        s_axi_bready = 1'b0;
        s_axi_awaddr = 5'h0C; s_axi_wdata = 32'hA5A50001; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1;
        aw_early = 1'b0;
        repeat (5) begin
            @(posedge clock); #1;
            if (s_axi_awready) aw_early = 1'b1;
        end
        check("aw_alone_waits", aw_early, 1'b0);
        s_axi_wvalid = 1'b1;
        wait_awready("stall_awready");
        @(posedge clock); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        check("stall_bvalid", s_axi_bvalid, 1'b1);
        s_axi_awaddr = 5'h08; s_axi_wdata = 32'h77; s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        exp_q.push_back(32'hA5A50001);
        s_axi_araddr = 5'h0C; s_axi_arvalid = 1'b1;
        ar_seen = 1'b0; aw_early = 1'b0; rd_done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clock); #1;
            if (ar_seen && !rd_done) begin
                s_axi_arvalid = 1'b0;
                rd_done = 1'b1;
                check("conc_rd_latency", s_axi_rvalid, 1'b1);
                check("conc_rd_data", s_axi_rdata, exp_q.pop_front());
            end else if (s_axi_arready) begin
                ar_seen = 1'b1;
            end
            if (s_axi_awready) aw_early = 1'b1;
            check("bvalid_held", s_axi_bvalid, 1'b1);
        end
        check("conc_rd_done", rd_done, 1'b1);
        check("aw_blocked_by_bvalid", aw_early, 1'b0);
        s_axi_bready = 1'b1;
        wait_awready("second_awready");
        @(posedge clock); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
        check("second_bvalid", s_axi_bvalid, 1'b1);
        check("second_poll", poll_interval, 32'h77);

        // Reset while a response is pending
        reset = 1'b1;
        @(posedge clock); #1;
        check("rst_drops_bvalid", s_axi_bvalid, 1'b0);
        reset = 1'b0; s_axi_bready = 1'b1;
        @(posedge clock); #1;
        axi_read(5'h08, 32'd16);
        axi_read(5'h0C, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ntp_client_axi_regs.md
Name: ntp_client_axi_regs

Overview:
AXI4-Lite slave register interface for the NTP client core. It sits between the PS-side AXI interconnect (S00_AXI) and the NTP client datapath. It exposes control registers (enable, server address, poll interval, scratch) to the core. It returns core status, a coherent 64-bit clock offset, and a sticky sync-done interrupt to software.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 5, byte address width; 8 word registers.
C_POLL_DEFAULT, 32'd16, reset value of POLL_INTERVAL.

Ports:
clock  in  1  system clock; all logic is on the rising edge.
reset  in  1  synchronous, active-high reset.
s_axi_awaddr  in  5  write address.
s_axi_awprot  in  3  ignored.
s_axi_awvalid  in  1  write address valid.
s_axi_awready  out  1  write address ready.
s_axi_wdata  in  32  write data.
s_axi_wstrb  in  4  byte enables.
s_axi_wvalid  in  1  write data valid.
s_axi_wready  out  1  write data ready.
s_axi_bresp  out  2  always 2'b00 (OKAY).
s_axi_bvalid  out  1  write response valid.
s_axi_bready  in  1  write response ready.
s_axi_araddr  in  5  read address.
s_axi_arprot  in  3  ignored.
s_axi_arvalid  in  1  read address valid.
s_axi_arready  out  1  read address ready.
s_axi_rdata  out  32  read data.
s_axi_rresp  out  2  always 2'b00.
s_axi_rvalid  out  1  read data valid.
s_axi_rready  in  1  read data ready.
ntp_enable  out  1  CTRL[0].
ntp_start  out  1  one-cycle start pulse.
server_addr  out  32  SERVER_ADDR register.
poll_interval  out  32  POLL_INTERVAL register.
core_busy  in  1  core transaction in progress.
sync_valid  in  1  offset has been computed at least once.
offset  in  64  signed clock offset, Q32.32 seconds.
sync_done  in  1  one-cycle pulse when the core updates offset.
irq  out  1  level interrupt.

Behaviour:
- Reset (synchronous, reset=1 at posedge):
  - awready=wready=bvalid=arready=rvalid=0; rdata=0.
  - CTRL=0, SERVER_ADDR=0, POLL_INTERVAL=C_POLL_DEFAULT, SCRATCH=0, IRQ_STATUS=0, offset shadow=0.
  - ntp_start=0, irq=0.
  - Reset mid-transaction aborts it; no response is issued.
- Write channel:
  - When awvalid & wvalid & !awready & !bvalid, assert awready and wready together for exactly one cycle. The register update happens in that same cycle.
  - bvalid rises the next cycle and holds until bready. No new write is accepted while bvalid=1.
  - AW without W, or W without AW, waits and is never accepted alone.
- Read channel:
  - When arvalid & !arready & !rvalid, assert arready for one cycle and latch the decoded data.
  - rvalid=1 the next cycle; rdata is stable and held until rready.
  - Read-to-data latency is 1 cycle after the handshake.
  - Read and write channels operate independently and may complete in the same cycle.
- Decode uses addr[4:2]; addr[1:0] is ignored. All 8 words are mapped; every access returns OKAY.
- WSTRB applies per byte to RW registers. RO registers ignore writes.
- Register map:
  - 0x00 CTRL RW: bit0 enable; bit1 start (writing 1 produces ntp_start=1 for the cycle after the write handshake, and bit1 reads 0); bit2 irq_en; bits31:3 stored.
  - 0x04 SERVER_ADDR RW.
  - 0x08 POLL_INTERVAL RW.
  - 0x0C SCRATCH RW.
  - 0x10 STATUS RO: {30'b0, sync_valid, core_busy}.
  - 0x14 OFFSET_HI RO: returns offset[63:32]. The same read handshake copies offset[31:0] into the shadow register.
  - 0x18 OFFSET_LO RO: returns the shadow, so a HI-then-LO read pair is coherent.
  - 0x1C IRQ_STATUS W1C: bit0 is set by sync_done. Writing 1 (with wstrb[0]) clears it. If set and clear happen in the same cycle, set wins.
- irq = IRQ_STATUS[0] & CTRL[2], registered (1-cycle delay).

Test Plan:
- Reset, then write 1,2,3,4 to 0x00,0x04,0x08,0x0C and read back -> rdata reads 0x1,0x2,0x3,0x4 (CTRL bit1 clear); ntp_enable=1, server_addr=2, poll_interval=3; bresp/rresp=0.
- Write 0xFFFFFFFF to 0x04 with wstrb=4'b0101 after a write of 0x12345678 -> readback 0x12FF56FF; a write to 0x10 is ignored and STATUS still tracks its inputs.
- Write 0x2 to CTRL -> ntp_start high for exactly 1 cycle; a CTRL read returns bit1=0.
- Set offset=0x00000001_80000000 and read 0x14; change offset to 0x2_00000000; read 0x18 -> 0x00000001 then 0x80000000.
- With CTRL[2]=1, pulse sync_done -> IRQ_STATUS=1 and irq=1. Write 1 to 0x1C in the same cycle as another sync_done -> bit stays 1. A later clear alone -> irq=0.
- Issue awvalid with wvalid delayed 5 cycles and bready held low 3 cycles -> awready waits for wvalid; bvalid is held; a second write stalls until bready. A concurrent read completes with 1-cycle latency. Asserting reset while bvalid=1 -> bvalid=0 on the next cycle.
